vinst_sched: RTL

Round-robin instruction scheduler in front of the `vinst_ctl` vector-instruction controller in `core`. It lets up to `NREQ` instruction sources share that single instruction port. It buffers granted instructions in a `DEPTH`-entry FIFO and presents them on the `iavail`/`ird` handshake that `vinst_ctl` already consumes. It also tags each instruction with its source and counts issued instructions for debug and `passed`-style checks.

---
 rtl/vinst_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vinst_sched.sv
// vinst_sched: round-robin scheduler that merges NREQ instruction sources
// into one FIFO-buffered iavail/ird port for vinst_ctl.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid/req_inst   per-requester instruction offer
//   req_ready            one-hot accept to the granted requester
//   hold                 suspend new grants (FIFO keeps draining)
//   inst/inst_id/iavail  registered FIFO head toward the consumer
//   ird                  consumer pop strobe
//   busy                 FIFO non-empty or any request pending
//   issued_count         total completed pops (wraps at 2^32)
module vinst_sched #(
   parameter  int NREQ   = 4,
   parameter  int INST_W = 144,
   parameter  int DEPTH  = 4,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*INST_W-1:0] req_inst,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   hold,
   output logic [INST_W-1:0]      inst,
   output logic [IDW-1:0]         inst_id,
   output logic                   iavail,
   input  logic                   ird,
   output logic                   busy,
   output logic [31:0]            issued_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = IDW + INST_W;

   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] win;
   logic           found;
   logic [PW-1:0]  wp_q, wp_d;
   logic [PW-1:0]  rp_q, rp_d;
   logic [PW:0]    cnt_q, cnt_d;
   logic [31:0]    issued_q, issued_d;
   logic [EW-1:0]  mem_q [DEPTH];
   logic [EW-1:0]  head;
   logic           full, empty;
   logic           push, pop;

   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);

   // Scan candidates rr_q, rr_q+1, ... (mod NREQ); first valid wins.
   always_comb begin
      int s;
      win   = '0;
      found = 1'b0;
      s     = 0;
      for (int k = 0; k < NREQ; k++) begin
         s = int'(rr_q) + k;
         if (s >= NREQ) s = s - NREQ;
         if (!found && req_valid[IDW'(s)]) begin
            found = 1'b1;
            win   = IDW'(s);
         end
      end
   end

   // Acceptance uses the registered full flag only, so a same-cycle
   // pop never frees a slot and ird has no path to req_ready.
   assign push      = found & ~hold & ~full & ~reset;
   assign pop       = ~empty & ird & ~reset;
   assign req_ready = push ? (NREQ'(1) << win) : '0;

   always_comb begin
      rr_d     = rr_q;
      wp_d     = wp_q;
      rp_d     = rp_q;
      cnt_d    = cnt_q;
      issued_d = issued_q;
      if (push) begin
         rr_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
         wp_d = wp_q + PW'(1);
      end
      if (pop) begin
         rp_d     = rp_q + PW'(1);
         issued_d = issued_q + 32'd1;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q     <= '0;
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         issued_q <= '0;
      end else begin
         rr_q     <= rr_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
      end
   end

   // Payload storage needs no reset; validity comes from cnt_q.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wp_q] <= {win, req_inst[win*INST_W +: INST_W]};
   end

   assign head         = mem_q[rp_q];
   assign inst         = head[INST_W-1:0];
   assign inst_id      = head[EW-1:INST_W];
   assign iavail       = ~empty;
   assign busy         = ~empty | (|req_valid);
   assign issued_count = issued_q;

endmodule
